traffic_sched: RTL and testbench

- Sequencer for an array of NUM_GEN traffic generators in the NoC test harness.
- Broadcasts Init to all generators, then routes host-supplied packet descriptors to individual generators as Fill ops.
- Then issues at most one Dequeue per cycle, round-robin among generators that are not done and hold a downstream credit.
- Tracks per-generator credits returned by the router input ports.

---
 rtl/traffic_sched_pkg.sv | 27 ++
 rtl/traffic_sched_rr_arbiter.sv | 32 +++
 rtl/traffic_sched.sv | 187 ++++++++++++++++++
 tb/tb_traffic_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_sched_pkg.sv
// Shared constants, op codes and FSM states for the traffic sequencer.
// Default sizes match the NoC harness generator array.
package traffic_sched_pkg;

  localparam int NUM_GEN_DEF   = 4;
  localparam int GEN_W_DEF     = 2;
  localparam int CREDITS_DEF   = 4;
  localparam int CREDIT_W_DEF  = 3;
  localparam int PKT_W_DEF     = 10;
  localparam int DATA_BIT_SIZE = 32;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_INIT = 3'd5,
    OP_FILL = 3'd6,
    OP_DEQ  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FILL,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/traffic_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps.
// Ports: req in, ptr in, grant (one-hot) / idx / valid out.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/traffic_sched.sv
// Traffic generator sequencer: Init broadcast, Fill routing, credit-gated
// round-robin Dequeue. Ports: start/num_packets, cfg handshake, gen_op/
// gen_data to generators, gen_done/credit_ret back, busy/run_done/cfg_err.
module traffic_sched
  import traffic_sched_pkg::*;
#(
  parameter int NUM_GEN  = NUM_GEN_DEF,
  parameter int GEN_W    = GEN_W_DEF,
  parameter int CREDITS  = CREDITS_DEF,
  parameter int CREDIT_W = CREDIT_W_DEF,
  parameter int PKT_W    = PKT_W_DEF,
  parameter int DATA_W   = DATA_BIT_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PKT_W-1:0]     num_packets,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [GEN_W-1:0]     cfg_gen,
  input  logic [DATA_W-1:0]    cfg_data,
  output logic [3*NUM_GEN-1:0] gen_op,
  output logic [DATA_W-1:0]    gen_data,
  input  logic [NUM_GEN-1:0]   gen_done,
  input  logic [NUM_GEN-1:0]   credit_ret,
  output logic                 busy,
  output logic                 run_done,
  output logic                 cfg_err
);

  state_e state, state_d;

  logic [PKT_W-1:0] npk;
  logic [NUM_GEN-1:0][PKT_W-1:0] fill_cnt, fill_cnt_d;
  logic [NUM_GEN-1:0][CREDIT_W-1:0] credit;
  logic [GEN_W-1:0] rr_ptr;
  logic run_first;

  logic [NUM_GEN-1:0] eligible, grant;
  logic [GEN_W-1:0] grant_idx;
  logic grant_any;

  logic accept, in_range, fill_ok, all_full, do_grant;
  logic [3*NUM_GEN-1:0] op_d;
  logic [DATA_W-1:0] data_d;
  logic err_d;

  assign accept   = cfg_valid && cfg_ready;
  assign in_range = int'(cfg_gen) < NUM_GEN;
  assign fill_ok  = accept && in_range
                    && (fill_cnt[cfg_gen] != npk);

  always_comb begin
    for (int g = 0; g < NUM_GEN; g++) begin
      eligible[g] = !gen_done[g]
                    && (credit[g] != '0);
    end
  end

  rr_arbiter #(
    .N     (NUM_GEN),
    .IDX_W (GEN_W)
  ) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .valid (grant_any)
  );

  // Grants are held off for the first RUN cycle so gen_done can settle.
  assign do_grant = (state == S_RUN) && !run_first
                    && grant_any;

  always_comb begin
    fill_cnt_d = fill_cnt;
    if (state == S_IDLE && start) begin
      fill_cnt_d = '0;
    end else if (fill_ok) begin
      fill_cnt_d[cfg_gen] = fill_cnt[cfg_gen] + PKT_W'(1);
    end
  end

  // Look-ahead on this cycle's beat so RUN follows the last beat at once.
  always_comb begin
    all_full = 1'b1;
    for (int g = 0; g < NUM_GEN; g++) begin
      if (fill_cnt_d[g] != npk) all_full = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: if (start) state_d = S_INIT;
      S_INIT: state_d = S_FILL;
      S_FILL: if (all_full) state_d = S_RUN;
      S_RUN: begin
        if (!run_first && (&gen_done)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d   = '0;
    data_d = '0;
    err_d  = cfg_err;
    unique case (state)
      S_IDLE: if (start) err_d = 1'b0;
      S_INIT: begin
        for (int g = 0; g < NUM_GEN; g++) begin
          op_d[3*g +: 3] = OP_INIT;
        end
        data_d[PKT_W-1:0] = npk;
      end
      S_FILL: begin
        if (fill_ok) begin
          op_d[3*int'(cfg_gen) +: 3] = OP_FILL;
          data_d = cfg_data;
        end else if (accept) begin
          err_d = 1'b1;
        end
      end
      S_RUN: begin
        if (do_grant) op_d[3*int'(grant_idx) +: 3] = OP_DEQ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_op    <= '0;
      gen_data  <= '0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      run_done  <= 1'b0;
      cfg_err   <= 1'b0;
      npk       <= '0;
      fill_cnt  <= '0;
      rr_ptr    <= '0;
      run_first <= 1'b0;
    end else begin
      gen_op    <= op_d;
      gen_data  <= data_d;
      cfg_ready <= (state_d == S_FILL);
      busy      <= (state_d != S_IDLE);
      run_done  <= (state_d == S_DONE);
      cfg_err   <= err_d;
      fill_cnt  <= fill_cnt_d;
      run_first <= (state != S_RUN)
                   && (state_d == S_RUN);
      if (state == S_IDLE && start) npk <= num_packets;
      if (do_grant) begin
        if (int'(grant_idx) == NUM_GEN - 1) rr_ptr <= '0;
        else rr_ptr <= grant_idx + GEN_W'(1);
      end
    end
  end

  // Return and grant together cancel; a return at full is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NUM_GEN; g++) begin
        credit[g] <= CREDIT_W'(CREDITS);
      end
    end else begin
      for (int g = 0; g < NUM_GEN; g++) begin
        if (credit_ret[g] && !(do_grant && grant[g])) begin
          if (credit[g] != CREDIT_W'(CREDITS)) begin
            credit[g] <= credit[g] + CREDIT_W'(1);
          end
        end else if (!credit_ret[g] && do_grant && grant[g]) begin
          credit[g] <= credit[g] - CREDIT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_sched.sv
// Scoreboard bench for traffic_sched: expected ops queued at stimulus,
// popped by a negedge monitor whenever any generator op is non-NOP.
module tb_traffic_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  num_packets = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_gen = '0;
  logic [31:0] cfg_data = '0;
  logic [11:0] gen_op;
  logic [31:0] gen_data;
  logic [3:0]  gen_done = '0;
  logic [3:0]  credit_ret = '0;
  logic        busy;
  logic        run_done;
  logic        cfg_err;

  typedef struct {
    logic [11:0] op;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   pass = 0;

  always #5 clk = ~clk;

  traffic_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_packets (num_packets),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_gen     (cfg_gen),
    .cfg_data    (cfg_data),
    .gen_op      (gen_op),
    .gen_data    (gen_data),
    .gen_done    (gen_done),
    .credit_ret  (credit_ret),
    .busy        (busy),
    .run_done    (run_done),
    .cfg_err     (cfg_err)
  );

  function automatic logic [11:0] one_op(input int g, input logic [2:0] op);
    logic [11:0] v;
    v = '0;
    v[3*g +: 3] = op;
    return v;
  endfunction

  function automatic logic [11:0] bcast(input logic [2:0] op);
    return {op, op, op, op};
  endfunction

  always @(negedge clk) begin
    if (rst_n && gen_op !== 12'h000) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected op=%h data=%h", gen_op, gen_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (gen_op !== mon_e.op || gen_data !== mon_e.data)
          $display("FAIL sb_op got op=%h data=%h want op=%h data=%h",
                   gen_op, gen_data, mon_e.op, mon_e.data);
        else pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [9:0] n);
    exp_q.push_back('{bcast(3'd5), {22'd0, n}});
    start = 1'b1;
    num_packets = n;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL start_busy got %b want 1", busy);
    else pass++;
  endtask

  task automatic send_beat(input logic [1:0] g, input logic [31:0] d);
    bit ok;
    ok = 0;
    cfg_valid = 1'b1;
    cfg_gen = g;
    cfg_data = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cfg_ready) ok = 1;
    end
    tick();
    cfg_valid = 1'b0;
    total++;
    if (!ok) $display("FAIL beat_timeout got ready=0 want ready=1");
    else pass++;
  endtask

  task automatic fill_beat(input logic [1:0] g, input logic [31:0] d);
    exp_q.push_back('{one_op(int'(g), 3'd6), d});
    send_beat(g, d);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0)
      $display("FAIL drain got %0d left want 0", exp_q.size());
    else pass++;
    tick();
  endtask

  task automatic wait_run_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (run_done) seen = 1;
    end
    total++;
    if (!seen) $display("FAIL run_done_seen got 0 want 1");
    else pass++;
    @(negedge clk);
    total++;
    if (run_done !== 1'b0) $display("FAIL run_done_pulse got %b want 0", run_done);
    else pass++;
    total++;
    if (busy !== 1'b0) $display("FAIL busy_drop got %b want 0", busy);
    else pass++;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++;
    if (gen_op !== 12'h000 || gen_data !== 32'h0 || busy !== 1'b0
        || cfg_ready !== 1'b0 || run_done !== 1'b0 || cfg_err !== 1'b0)
      $display("FAIL reset_state got op=%h d=%h b=%b r=%b rd=%b e=%b want zeros",
               gen_op, gen_data, busy, cfg_ready, run_done, cfg_err);
    else pass++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_fill();
    do_start(10'd2);
    fill_beat(2'd0, 32'hA000_0001);
    fill_beat(2'd0, 32'hA000_0002);
    send_beat(2'd0, 32'hA000_0003);
    total++;
    if (cfg_err !== 1'b1) $display("FAIL quota_err got %b want 1", cfg_err);
    else pass++;
    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) $display("FAIL pre_reset_q got %0d want 0", exp_q.size());
    else pass++;
    rst_n = 1'b0;
    #1;
    total++;
    if (gen_op !== 12'h000 || busy !== 1'b0 || cfg_ready !== 1'b0
        || cfg_err !== 1'b0)
      $display("FAIL async_reset got op=%h b=%b r=%b e=%b want 0",
               gen_op, busy, cfg_ready, cfg_err);
    else pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) tick();
    total++;
    if (busy !== 1'b0) $display("FAIL reset_idle got busy=%b want 0", busy);
    else pass++;
  endtask

  task automatic test_fill_run();
    do_start(10'd2);
    for (int r = 0; r < 2; r++)
      for (int g = 0; g < 4; g++)
        fill_beat(2'(g), 32'hF000_0000 + 32'(r * 16 + g));
    total++;
    if (cfg_ready !== 1'b0) $display("FAIL run_entry got ready=%b want 0", cfg_ready);
    else pass++;
    for (int r = 0; r < 4; r++)
      for (int g = 0; g < 4; g++)
        exp_q.push_back('{one_op(g, 3'd7), 32'h0});
    wait_drain(60);
    repeat (5) tick();
    exp_q.push_back('{one_op(2, 3'd7), 32'h0});
    credit_ret = 4'b0100;
    tick();
    credit_ret = 4'b0000;
    wait_drain(10);
    repeat (3) tick();
  endtask

  task automatic test_credit();
    exp_q.push_back('{one_op(1, 3'd7), 32'h0});
    credit_ret = 4'b0010;
    tick();
    credit_ret = 4'b0000;
    wait_drain(10);
    repeat (4) tick();
    gen_done = 4'b0001;
    credit_ret = 4'b0001;
    repeat (6) tick();
    credit_ret = 4'b0000;
    gen_done = 4'b0000;
    for (int i = 0; i < 4; i++) exp_q.push_back('{one_op(0, 3'd7), 32'h0});
    wait_drain(20);
    repeat (4) tick();
  endtask

  task automatic test_gen_done();
    gen_done = 4'b0101;
    credit_ret = 4'b1111;
    exp_q.push_back('{one_op(1, 3'd7), 32'h0});
    exp_q.push_back('{one_op(3, 3'd7), 32'h0});
    exp_q.push_back('{one_op(1, 3'd7), 32'h0});
    exp_q.push_back('{one_op(3, 3'd7), 32'h0});
    repeat (2) tick();
    credit_ret = 4'b0000;
    wait_drain(20);
    repeat (3) tick();
    gen_done = 4'b1111;
    wait_run_done();
  endtask

  task automatic test_zero_run();
    do_start(10'd0);
    send_beat(2'd2, 32'hDEAD_BEEF);
    total++;
    if (cfg_err !== 1'b1) $display("FAIL zero_err got %b want 1", cfg_err);
    else pass++;
    wait_run_done();
    total++;
    if (cfg_err !== 1'b1) $display("FAIL err_sticky got %b want 1", cfg_err);
    else pass++;
    do_start(10'd0);
    total++;
    if (cfg_err !== 1'b0) $display("FAIL err_clear got %b want 0", cfg_err);
    else pass++;
    wait_run_done();
    wait_drain(5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_reset_mid_fill();
    test_fill_run();
    test_credit();
    test_gen_done();
    test_zero_run();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
